// File: rtl/ol_link_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ol_pkg
// Shared definitions for the optical link sequencer: the sequencer state
// encoding, the retry counter width and a saturating retry increment.
// No ports (package).
// -----------------------------------------------------------------------------
package ol_pkg;

   localparam int RETRY_W = 4;
   localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOWER = 3'd1,
      ST_TRAIN = 3'd2,
      ST_CHECK = 3'd3,
      ST_UP    = 3'd4,
      ST_FAIL  = 3'd5
   } seq_state_e;

   // Retry count sticks at its maximum instead of wrapping to zero.
   function automatic logic [RETRY_W-1:0] retry_sat_inc(input logic [RETRY_W-1:0] cnt);
      return (cnt == RETRY_MAX) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/ol_link_sequencer_if.sv
// -----------------------------------------------------------------------------
// ol_link_sequencer_if
// Bundles the link sequencer's control, per-lane status and result signals.
//   master : drives enable and the per-lane lane_send_err / lane_error /
//            lane_ena_rx inputs; observes the sequencer outputs.
//   slave  : the sequencer side; drives lane_live, lane_ok, link_up,
//            link_fail and retry_cnt.
// -----------------------------------------------------------------------------
interface ol_link_sequencer_if
   import ol_pkg::*;
#(
   parameter int N_LANES = 4
);

   logic                 enable;
   logic [N_LANES-1:0]   lane_send_err;
   logic [N_LANES-1:0]   lane_error;
   logic [N_LANES-1:0]   lane_ena_rx;
   logic [N_LANES-1:0]   lane_live;
   logic [N_LANES-1:0]   lane_ok;
   logic                 link_up;
   logic                 link_fail;
   logic [RETRY_W-1:0]   retry_cnt;

   modport master (
      output enable, lane_send_err, lane_error, lane_ena_rx,
      input  lane_live, lane_ok, link_up, link_fail, retry_cnt
   );

   modport slave (
      input  enable, lane_send_err, lane_error, lane_ena_rx,
      output lane_live, lane_ok, link_up, link_fail, retry_cnt
   );

endinterface

// File: rtl/ol_link_sequencer_lane_monitor.sv
// -----------------------------------------------------------------------------
// ol_lane_monitor
// Per-lane result latch and (optionally) link-loss detector.
// Optional feature macro: OL_SEQ_LOSS_MONITOR_EN (loss counter compiled in).
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : clears done/ok at the start of a training attempt
//   capture   : training window open; strobes are recorded only while high
//   send_err  : one-cycle result strobe from the lane controller
//   error     : lane error flag, valid with send_err (0 = pass)
//   ena_rx    : lane receiver status (0 = receiving)
//   up        : link is in UP; loss counting is only active here
//   done      : this lane has reported in the current attempt
//   ok        : this lane passed in the current / last attempt
//   loss      : this cycle completes LOSS_CYC consecutive ena_rx-high cycles
// -----------------------------------------------------------------------------
module ol_lane_monitor
   import ol_pkg::*;
#(
   parameter int unsigned LOSS_CYC = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic capture,
   input  logic send_err,
   input  logic error,
   input  logic ena_rx,
   input  logic up,
   output logic done,
   output logic ok,
   output logic loss
);

   // Only the first strobe of an attempt counts; later ones are ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
         ok   <= 1'b0;
      end else if (clr) begin
         done <= 1'b0;
         ok   <= 1'b0;
      end else if (capture && send_err && !done) begin
         done <= 1'b1;
         ok   <= ~error;
      end
   end

`ifdef OL_SEQ_LOSS_MONITOR_EN
   localparam int LOSS_W = $clog2(LOSS_CYC + 1);

   logic [LOSS_W-1:0] loss_cnt;

   // Counts consecutive not-receiving cycles while UP; any 0 restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loss_cnt <= '0;
      end else if (up && ena_rx) begin
         loss_cnt <= loss_cnt + 1'b1;
      end else begin
         loss_cnt <= '0;
      end
   end

   assign loss = up && ena_rx && (loss_cnt == LOSS_W'(LOSS_CYC - 1));
`else
   logic unused_loss_inputs;
   assign unused_loss_inputs = ena_rx ^ up ^ (LOSS_CYC == 0);
   assign loss = 1'b0;
`endif

endmodule

// File: rtl/ol_link_sequencer.sv
// -----------------------------------------------------------------------------
// ol_link_sequencer
// Brings up an N_LANES optical link: holds LIVE low for HOLD_CYC cycles,
// raises LIVE and collects one pass/fail strobe per lane (bounded by
// TRAIN_TO cycles), then either declares the link UP or retries, giving up
// in FAIL after MAX_RETRY failed attempts. enable=0 returns to IDLE.
// Optional feature macro: OL_SEQ_LOSS_MONITOR_EN (in UP, LOSS_CYC consecutive
// ena_rx-high cycles on any lane forces a new attempt).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ol_link_sequencer_if.slave (enable, per-lane inputs, all outputs)
// All outputs are registered.
// -----------------------------------------------------------------------------
module ol_link_sequencer
   import ol_pkg::*;
#(
   parameter int          N_LANES   = 4,
   parameter int          HOLD_CYC  = 16,
   parameter int unsigned TRAIN_TO  = 24'h180000,
   parameter int          MAX_RETRY = 3,
   parameter int unsigned LOSS_CYC  = 256
) (
   input  logic                clk,
   input  logic                rst,
   ol_link_sequencer_if.slave  bus
);

   localparam int HOLD_W = $clog2(HOLD_CYC + 1);
   localparam int TMO_W  = $clog2(TRAIN_TO + 1);

   seq_state_e          state;
   seq_state_e          state_nxt;

   logic [HOLD_W-1:0]   hold_cnt;
   logic [TMO_W-1:0]    tmo_cnt;

   logic [N_LANES-1:0]  done;
   logic [N_LANES-1:0]  ok;
   logic [N_LANES-1:0]  loss;

   logic                train_clr;
   logic                train_cap;
   logic                all_done;
   logic                tmo_last;
   logic                hold_last;
   logic [RETRY_W-1:0]  retry_inc;

   logic [N_LANES-1:0]  live_q, live_nxt;
   logic                up_q, fail_q;
   logic [RETRY_W-1:0]  retry_q, retry_nxt;

   // ---------------------------------------------------------------- lanes
   for (genvar i = 0; i < N_LANES; i++) begin : g_lane
      ol_lane_monitor #(
         .LOSS_CYC (LOSS_CYC)
      ) u_mon (
         .clk      (clk),
         .rst      (rst),
         .clr      (train_clr),
         .capture  (train_cap),
         .send_err (bus.lane_send_err[i]),
         .error    (bus.lane_error[i]),
         .ena_rx   (bus.lane_ena_rx[i]),
         .up       (state == ST_UP),
         .done     (done[i]),
         .ok       (ok[i]),
         .loss     (loss[i])
      );
   end

   // Latches clear on the edge that enters TRAIN; strobes arriving together
   // with enable=0 are dropped so the previous lane_ok is kept.
   assign train_clr = (state != ST_TRAIN) && (state_nxt == ST_TRAIN);
   assign train_cap = (state == ST_TRAIN) && bus.enable;

   // Counting this cycle's strobes lets CHECK follow the last strobe directly.
   assign all_done  = &(done | bus.lane_send_err);
   assign tmo_last  = (tmo_cnt == TMO_W'(TRAIN_TO - 1));
   assign hold_last = (hold_cnt == HOLD_W'(HOLD_CYC - 1));
   assign retry_inc = retry_sat_inc(retry_q);

   // ------------------------------------------------------- state register
   // NOTE: flops use non-blocking assignments so every register samples the
   // pre-edge values of its inputs regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------ next-state logic
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      if (!bus.enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state_nxt = ST_LOWER;
            ST_LOWER: if (hold_last) state_nxt = ST_TRAIN;
            ST_TRAIN: if (all_done || tmo_last) state_nxt = ST_CHECK;
            ST_CHECK: begin
               if (&ok) begin
                  state_nxt = ST_UP;
               end else if (retry_inc == RETRY_W'(MAX_RETRY)) begin
                  state_nxt = ST_FAIL;
               end else begin
                  state_nxt = ST_LOWER;
               end
            end
            ST_UP:    if (|loss) state_nxt = ST_LOWER;
            ST_FAIL:  state_nxt = ST_FAIL;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------- output logic
   // Outputs are computed from the state being entered and registered, so
   // they change on the same edge as the state.
   always_comb begin
      live_nxt  = '0;
      retry_nxt = retry_q;
      case (state_nxt)
         ST_TRAIN, ST_CHECK, ST_UP: live_nxt = '1;
         default:                   live_nxt = '0;
      endcase
      if (state_nxt == ST_IDLE || state_nxt == ST_UP) begin
         retry_nxt = '0;
      end else if (state == ST_CHECK) begin
         retry_nxt = retry_inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         live_q  <= '0;
         up_q    <= 1'b0;
         fail_q  <= 1'b0;
         retry_q <= '0;
      end else begin
         live_q  <= live_nxt;
         up_q    <= (state_nxt == ST_UP);
         fail_q  <= (state_nxt == ST_FAIL);
         retry_q <= retry_nxt;
      end
   end

   // Hold and timeout counters run only while their state persists, so they
   // restart from zero on every entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
         tmo_cnt  <= '0;
      end else begin
         hold_cnt <= (state == ST_LOWER && state_nxt == ST_LOWER) ? hold_cnt + 1'b1 : '0;
         tmo_cnt  <= (state == ST_TRAIN && state_nxt == ST_TRAIN) ? tmo_cnt + 1'b1 : '0;
      end
   end

   assign bus.lane_live = live_q;
   assign bus.lane_ok   = ok;
   assign bus.link_up   = up_q;
   assign bus.link_fail = fail_q;
   assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_ol_link_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ol_link_sequencer
// Directed bench for ol_link_sequencer with a shortened training timeout.
// Inputs change 1 time unit after each rising edge; outputs are read there too.
// -----------------------------------------------------------------------------
module tb_ol_link_sequencer;

   localparam int          N_LANES   = 4;
   localparam int          HOLD_CYC  = 16;
   localparam int unsigned TRAIN_TO  = 1200;
   localparam int          MAX_RETRY = 3;
   localparam int unsigned LOSS_CYC  = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

   ol_link_sequencer_if #(.N_LANES(N_LANES)) bus ();

   ol_link_sequencer #(
      .N_LANES   (N_LANES),
      .HOLD_CYC  (HOLD_CYC),
      .TRAIN_TO  (TRAIN_TO),
      .MAX_RETRY (MAX_RETRY),
      .LOSS_CYC  (LOSS_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Ticks until lane_live equals exp; returns the tick count (budget if never).
   task automatic wait_live(input logic [N_LANES-1:0] exp, input int budget, output int cnt);
      cnt = 0;
      while (bus.lane_live !== exp && cnt < budget) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      bus.enable        = 1'b0;
      bus.lane_send_err = '0;
      bus.lane_error    = '0;
      bus.lane_ena_rx   = '0;

      // ---------------- reset state
      rst = 1'b1;
      repeat (3) tick();
      check("rst_live",  bus.lane_live, 0);
      check("rst_ok",    bus.lane_ok,   0);
      check("rst_up",    bus.link_up,   0);
      check("rst_fail",  bus.link_fail, 0);
      check("rst_retry", bus.retry_cnt, 0);
      rst = 1'b0;
      tick();
      check("idle_live", bus.lane_live, 0);

      // ---------------- all lanes pass at TRAIN cycle 1000
      bus.enable = 1'b1;
      wait_live(4'hF, 40, n);
      check("a_ticks_to_train", n, 17);
      repeat (1000) tick();
      bus.lane_send_err = 4'hF;
      bus.lane_error    = 4'h0;
      tick();
      bus.lane_send_err = '0;
      check("a_check_up",   bus.link_up, 0);
      check("a_check_ok",   bus.lane_ok, 4'hF);
      tick();
      check("a_up",         bus.link_up,   1);
      check("a_ok",         bus.lane_ok,   4'hF);
      check("a_retry",      bus.retry_cnt, 0);
      check("a_live",       bus.lane_live, 4'hF);
      check("a_fail",       bus.link_fail, 0);

`ifdef OL_SEQ_LOSS_MONITOR_EN
      // ---------------- loss monitor: 255 cycles tolerated, 256 drops the link
      bus.lane_ena_rx = 4'h1;
      repeat (255) tick();
      bus.lane_ena_rx = 4'h0;
      check("loss255_up", bus.link_up, 1);
      tick();
      bus.lane_ena_rx = 4'h1;
      repeat (256) tick();
      bus.lane_ena_rx = 4'h0;
      check("loss256_up",   bus.link_up,   0);
      check("loss256_live", bus.lane_live, 0);
`else
      // ---------------- without the loss monitor, ena_rx is ignored in UP
      bus.lane_ena_rx = 4'hF;
      repeat (300) tick();
      bus.lane_ena_rx = 4'h0;
      check("noloss_up",   bus.link_up,   1);
      check("noloss_live", bus.lane_live, 4'hF);
`endif

      bus.enable = 1'b0;
      tick();
      check("a_idle_up",    bus.link_up,   0);
      check("a_idle_live",  bus.lane_live, 0);
      check("a_idle_retry", bus.retry_cnt, 0);
      check("a_idle_ok",    bus.lane_ok,   4'hF);

      // ---------------- lane 2 fails every attempt
      bus.enable = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_live(4'hF, 40, n);
         check("b_ticks_to_train", n, (k == 1) ? 17 : 16);
         bus.lane_send_err = 4'hF;
         bus.lane_error    = 4'h4;
         tick();
         bus.lane_send_err = '0;
         bus.lane_error    = '0;
         check("b_ok", bus.lane_ok, 4'hB);
         tick();
         check("b_retry", bus.retry_cnt, k);
         check("b_live",  bus.lane_live, 0);
         check("b_fail",  bus.link_fail, (k == 3) ? 1 : 0);
      end
      repeat (20) tick();
      check("b_fail_hold",  bus.link_fail, 1);
      check("b_fail_live",  bus.lane_live, 0);
      check("b_fail_ok",    bus.lane_ok,   4'hB);
      check("b_fail_retry", bus.retry_cnt, 3);
      check("b_fail_up",    bus.link_up,   0);
      bus.enable = 1'b0;
      tick();
      check("b_exit_fail",  bus.link_fail, 0);
      check("b_exit_retry", bus.retry_cnt, 0);

      // ---------------- lane 3 never reports: timeout
      bus.enable = 1'b1;
      wait_live(4'hF, 40, n);
      check("c_ticks_to_train", n, 17);
      bus.lane_send_err = 4'h7;
      tick();
      bus.lane_send_err = '0;
      wait_live(4'h0, 1300, n);
      check("c_ticks_to_lower", n, 1200);
      check("c_ok",    bus.lane_ok,   4'h7);
      check("c_retry", bus.retry_cnt, 1);
      wait_live(4'hF, 40, n);
      check("c_hold_len", n, 16);
      bus.enable = 1'b0;
      tick();
      check("c_idle_retry", bus.retry_cnt, 0);

      // ---------------- enable drops together with the last strobe
      bus.enable = 1'b1;
      wait_live(4'hF, 40, n);
      check("d_ticks_to_train", n, 17);
      bus.lane_send_err = 4'h7;
      tick();
      bus.lane_send_err = 4'h8;
      bus.enable        = 1'b0;
      tick();
      bus.lane_send_err = '0;
      check("d_up",    bus.link_up,   0);
      check("d_live",  bus.lane_live, 0);
      check("d_retry", bus.retry_cnt, 0);
      check("d_fail",  bus.link_fail, 0);
      repeat (3) tick();
      check("d_up_later", bus.link_up, 0);

      // ---------------- reset in the middle of training
      bus.enable = 1'b1;
      wait_live(4'hF, 40, n);
      check("e_ticks_to_train", n, 17);
      bus.lane_send_err = 4'h3;
      tick();
      bus.lane_send_err = '0;
      check("e_partial_ok", bus.lane_ok, 4'h3);
      #2;
      rst = 1'b1;
      #1;
      check("e_rst_live",  bus.lane_live, 0);
      check("e_rst_ok",    bus.lane_ok,   0);
      check("e_rst_up",    bus.link_up,   0);
      check("e_rst_fail",  bus.link_fail, 0);
      check("e_rst_retry", bus.retry_cnt, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_live(4'hF, 40, n);
      check("e_restart_ticks", n, 17);
      bus.lane_send_err = 4'hF;
      tick();
      bus.lane_send_err = '0;
      tick();
      check("e_up", bus.link_up, 1);
      check("e_ok", bus.lane_ok, 4'hF);
      bus.enable = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
